// File: rtl/mux_arb_pkg.sv
// Shared types for the four-way round-robin capture arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle; the arbiter uses the slave side, the driver of requests the master side.
interface mux4_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [3:0]        req;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [3:0]        gnt;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output req, in0, in1, in2, in3, out_ready,
    input  gnt, out_data, out_src, out_valid
  );

  modport slave (
    input  req, in0, in1, in2, in3, out_ready,
    output gnt, out_data, out_src, out_valid
  );
endinterface

// File: rtl/MUX4x1_8bit.sv
// Plain 4:1 word multiplexer used to pick the granted requester's data.
module MUX4x1_8bit #(
  parameter int W = 8
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [1:0]   sel2,
  output logic [W-1:0] out
);
  always_comb begin
    unique case (sel2)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that captures one requester's word into a single-entry
// output register, with a combinational one-hot grant.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  mux4_rr_arbiter_if.slave    bus
);

  state_t            state, state_nx;
  sel_t              ptr;
  sel_t              winner;
  sel_t              idx;
  logic              found;
  logic              slot_free;
  logic              grant;
  logic [DATA_W-1:0] mux_y;
  logic [DATA_W-1:0] data_q;
  sel_t              src_q;

  // Scan from ptr upward; walking offsets high-to-low lets the nearest hit win.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + sel_t'(k);
      if (bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign slot_free = (state == EMPTY) || (bus.out_ready && state == FULL);
  assign grant     = slot_free && found && !reset;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nx = state;
    bus.gnt  = '0;
    if (grant) begin
      state_nx         = FULL;
      bus.gnt[winner]  = 1'b1;
    end else if (slot_free) begin
      state_nx = EMPTY;
    end
  end

  MUX4x1_8bit #(.W(DATA_W)) u_mux (
    .in0  (bus.in0),
    .in1  (bus.in1),
    .in2  (bus.in2),
    .in3  (bus.in3),
    .sel2 (winner),
    .out  (mux_y)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      ptr    <= '0;
      data_q <= '0;
      src_q  <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        data_q <= mux_y;
        src_q  <= winner;
        ptr    <= winner + sel_t'(1);
      end
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized bench for mux4_rr_arbiter against a behavioural model.
module tb_mux4_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset;

  mux4_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

  mux4_rr_arbiter #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: one-entry holding slot plus a rotating "who goes first" index.
  bit          m_full;
  logic [7:0]  m_data;
  int          m_src;
  int          m_ptr;

  function automatic logic [7:0] in_of(int i);
    case (i)
      0:       return bus.in0;
      1:       return bus.in1;
      2:       return bus.in2;
      default: return bus.in3;
    endcase
  endfunction

  function automatic int model_winner();
    if (reset) return -1;
    if (m_full && !bus.out_ready) return -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (bus.req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_gnt();
    int w;
    w = model_winner();
    if (w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  task automatic model_edge();
    int w;
    w = model_winner();
    if (reset) begin
      m_full = 0; m_data = 8'h00; m_src = 0; m_ptr = 0;
    end else if (w >= 0) begin
      m_data = in_of(w); m_src = w; m_ptr = (w + 1) % 4; m_full = 1;
    end else if (!m_full || bus.out_ready) begin
      m_full = 0;
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic rdy, input logic rst);
    @(negedge clk);
    bus.req       = r;
    bus.out_ready = rdy;
    reset         = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_data(input logic [7:0] a, b, c, d);
    bus.in0 = a; bus.in1 = b; bus.in2 = c; bus.in3 = d;
  endtask

  task automatic test_reset();
    drive(4'b1111, 1'b1, 1'b1);
    n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.gnt); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_src !== 2'd0) $display("FAIL reset_src: got %0d want 0", bus.out_src); else n_pass++;
  endtask

  task automatic test_single();
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    drive(4'b0100, 1'b0, 1'b0);
    n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", bus.gnt); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 8'hA5) $display("FAIL single_data: got %h want a5", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_src !== 2'd2) $display("FAIL single_src: got %0d want 2", bus.out_src); else n_pass++;
    drive(4'b0100, 1'b0, 1'b0);
    n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL single_held_gnt: got %b want 0000", bus.gnt); else n_pass++;
    tick();
  endtask

  task automatic test_fairness();
    logic [7:0] exp_d;
    drive(4'b0000, 1'b0, 1'b1); tick();
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 1'b1, 1'b0);
      n_checks++; if (bus.gnt !== 4'(1 << (k % 4))) $display("FAIL fair_gnt[%0d]: got %b want %b", k, bus.gnt, 4'(1 << (k % 4))); else n_pass++;
      tick();
      exp_d = 8'h10 + 8'(k % 4);
      n_checks++; if (bus.out_data !== exp_d) $display("FAIL fair_data[%0d]: got %h want %h", k, bus.out_data, exp_d); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL fair_valid[%0d]: got %b want 1", k, bus.out_valid); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    drive(4'b0000, 1'b0, 1'b1); tick();
    set_data(8'h21, 8'h22, 8'h23, 8'h24);
    drive(4'b0100, 1'b1, 1'b0); tick();
    drive(4'b0101, 1'b1, 1'b0);
    n_checks++; if (bus.gnt !== 4'b0001) $display("FAIL wrap_gnt0: got %b want 0001", bus.gnt); else n_pass++;
    tick();
    n_checks++; if (bus.out_src !== 2'd0) $display("FAIL wrap_src0: got %0d want 0", bus.out_src); else n_pass++;
    drive(4'b0101, 1'b1, 1'b0);
    n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL wrap_gnt2: got %b want 0100", bus.gnt); else n_pass++;
    tick();
    n_checks++; if (bus.out_data !== 8'h23) $display("FAIL wrap_data2: got %h want 23", bus.out_data); else n_pass++;
  endtask

  task automatic test_backpressure();
    drive(4'b0000, 1'b0, 1'b1); tick();
    set_data(8'h3C, 8'h5A, 8'h00, 8'h00);
    drive(4'b0001, 1'b0, 1'b0); tick();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0010, 1'b0, 1'b0);
      n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL bp_gnt[%0d]: got %b want 0000", k, bus.gnt); else n_pass++;
      tick();
      n_checks++; if (bus.out_data !== 8'h3C) $display("FAIL bp_data[%0d]: got %h want 3c", k, bus.out_data); else n_pass++;
    end
    drive(4'b0010, 1'b1, 1'b0);
    n_checks++; if (bus.gnt !== 4'b0010) $display("FAIL bp_release_gnt: got %b want 0010", bus.gnt); else n_pass++;
    tick();
    n_checks++; if (bus.out_data !== 8'h5A) $display("FAIL bp_release_data: got %h want 5a", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_src !== 2'd1) $display("FAIL bp_release_src: got %0d want 1", bus.out_src); else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_data(8'h01, 8'h02, 8'h03, 8'h77);
    drive(4'b0001, 1'b0, 1'b0); tick();
    drive(4'b1000, 1'b0, 1'b1);
    n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL rstmid_gnt: got %b want 0000", bus.gnt); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", bus.out_data); else n_pass++;
    drive(4'b1000, 1'b0, 1'b0);
    n_checks++; if (bus.gnt !== 4'b1000) $display("FAIL rstmid_regnt: got %b want 1000", bus.gnt); else n_pass++;
    tick();
    n_checks++; if (bus.out_src !== 2'd3 || bus.out_data !== 8'h77) $display("FAIL rstmid_capture: got src %0d data %h want 3 77", bus.out_src, bus.out_data); else n_pass++;
  endtask

  task automatic test_empty_ready();
    drive(4'b0000, 1'b0, 1'b1); tick();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0000, 1'(k % 2), 1'b0);
      n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL idle_gnt[%0d]: got %b want 0000", k, bus.gnt); else n_pass++;
      tick();
      n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_src !== 2'd0)
        $display("FAIL idle_out[%0d]: got v%b d%h s%0d want v0 d00 s0", k, bus.out_valid, bus.out_data, bus.out_src); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      drive(4'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0));
      n_checks++; if (bus.gnt !== model_gnt()) $display("FAIL rand_gnt[%0d]: got %b want %b", c, bus.gnt, model_gnt()); else n_pass++;
      n_checks++; if (!$onehot0(bus.gnt)) $display("FAIL rand_onehot[%0d]: got %b want at most one bit", c, bus.gnt); else n_pass++;
      tick();
      n_checks++; if (bus.out_valid !== m_full) $display("FAIL rand_valid[%0d]: got %b want %b", c, bus.out_valid, m_full); else n_pass++;
      n_checks++; if (bus.out_data !== m_data) $display("FAIL rand_data[%0d]: got %h want %h", c, bus.out_data, m_data); else n_pass++;
      n_checks++; if (bus.out_src !== 2'(m_src)) $display("FAIL rand_src[%0d]: got %0d want %0d", c, bus.out_src, m_src); else n_pass++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    m_full = 0; m_data = 8'h00; m_src = 0; m_ptr = 0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_empty_ready();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
